// File: rtl/apb_cmd_queue_if.sv
// Host command / APB master / response signal bundle for apb_cmd_queue.
// The slave modport is the queue's view; master is the host-and-bus side.
interface apb_cmd_queue_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          CMD_VALID;
  logic          CMD_READY;
  logic          CMD_WRITE;
  logic [31:0]   CMD_ADDR;
  logic [31:0]   CMD_WDATA;
  logic [LW-1:0] LEVEL;

  logic          TRANSFER;
  logic          PWRITE_MASTER;
  logic [31:0]   PADDR_MASTER;
  logic [31:0]   PWDATA_MASTER;
  logic          PSEL;
  logic          PENABLE;
  logic          PREADY;
  logic [31:0]   PRDATA_MASTER;

  logic          RSP_VALID;
  logic [31:0]   RSP_DATA;
  logic [31:0]   RSP_ADDR;

  modport slave (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
    input  PSEL, PENABLE, PREADY, PRDATA_MASTER,
    output CMD_READY, LEVEL,
    output TRANSFER, PWRITE_MASTER, PADDR_MASTER, PWDATA_MASTER,
    output RSP_VALID, RSP_DATA, RSP_ADDR
  );

  modport master (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
    output PSEL, PENABLE, PREADY, PRDATA_MASTER,
    input  CMD_READY, LEVEL,
    input  TRANSFER, PWRITE_MASTER, PADDR_MASTER, PWDATA_MASTER,
    input  RSP_VALID, RSP_DATA, RSP_ADDR
  );
endinterface

// File: rtl/apb_cmd_queue.sv
// Command FIFO in front of an APB master: presents the oldest command as a
// transfer request, pops it on bus completion and returns read data.
module apb_cmd_queue #(
  parameter int DEPTH = 4
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_cmd_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [LW-1:0] level_q, level_d;
  cmd_t          cur_q, cur_d;
  logic          transfer_q, transfer_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [31:0]   rsp_addr_q, rsp_addr_d;

  cmd_t          cmd_in, head, load_cmd;
  logic          cmd_ready, push, done, load;

  assign cmd_in    = {bus.CMD_WRITE, bus.CMD_ADDR, bus.CMD_WDATA};
  assign cmd_ready = (level_q < LW'(DEPTH));
  assign push      = bus.CMD_VALID && cmd_ready;
  assign done      = (state_q == ACCESS) && bus.PSEL && bus.PENABLE && bus.PREADY;
  assign rd_nxt    = rd_ptr_q + AW'(1);
  assign head      = mem_q[rd_ptr_q];

  // The in-flight command stays in the FIFO until the bus completes it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (done) rd_ptr_d = rd_nxt;
    level_d = level_q + LW'(push) - LW'(done);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_q != '0) state_d = SETUP;
      SETUP:   if (bus.PSEL && !bus.PENABLE) state_d = ACCESS;
      ACCESS:  if (done) state_d = (level_d != '0) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    load_cmd = head;
    if (state_q == IDLE && level_q != '0) begin
      load = 1'b1;
    end else if (done && level_d != '0) begin
      load = 1'b1;
      // If only the finishing command was queued, the follower is arriving now.
      load_cmd = (level_q > LW'(1)) ? mem_q[rd_nxt] : cmd_in;
    end
    cur_d       = load ? load_cmd : cur_q;
    transfer_d  = load ? 1'b1 : (done ? 1'b0 : transfer_q);
    rsp_valid_d = done && !cur_q.write;
    rsp_data_d  = rsp_valid_d ? bus.PRDATA_MASTER : rsp_data_q;
    rsp_addr_d  = rsp_valid_d ? cur_q.addr : rsp_addr_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cur_q       <= '0;
      transfer_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cur_q       <= cur_d;
      transfer_q  <= transfer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge PCLK) mem_q <= mem_d;

  assign bus.CMD_READY     = cmd_ready;
  assign bus.LEVEL         = level_q;
  assign bus.TRANSFER      = transfer_q;
  assign bus.PWRITE_MASTER = cur_q.write;
  assign bus.PADDR_MASTER  = cur_q.addr;
  assign bus.PWDATA_MASTER = cur_q.wdata;
  assign bus.RSP_VALID     = rsp_valid_q;
  assign bus.RSP_DATA      = rsp_data_q;
  assign bus.RSP_ADDR      = rsp_addr_q;
endmodule

// File: tb/tb_apb_cmd_queue.sv
// Bench for apb_cmd_queue: directed scenarios plus a randomized run scored
// against a queue model of the command stream and read responses.
module tb_apb_cmd_queue;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic clk, rst;
  int   checks, errors;

  apb_cmd_queue_if #(.DEPTH(DEPTH)) bus ();
  apb_cmd_queue #(.DEPTH(DEPTH)) dut (.PCLK(clk), .PRESET(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.CMD_VALID = 0; bus.CMD_WRITE = 0; bus.CMD_ADDR = 0; bus.CMD_WDATA = 0;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0; bus.PRDATA_MASTER = 0;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.CMD_VALID = 1; bus.CMD_WRITE = w; bus.CMD_ADDR = a; bus.CMD_WDATA = d;
    tick();
    bus.CMD_VALID = 0;
  endtask

  task automatic wait_transfer(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.TRANSFER === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  // Acts as the APB master/slave pair: setup, ws wait states, then completion.
  task automatic apb_run(input int ws, input logic [31:0] rd);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PREADY = 0;
    tick();
    bus.PENABLE = 1;
    repeat (ws) tick();
    bus.PREADY = 1; bus.PRDATA_MASTER = rd;
    tick();
    bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.CMD_VALID = 1; bus.CMD_WRITE = 1; bus.CMD_ADDR = 32'h100; bus.CMD_WDATA = 32'h55;
    tick(); tick();
    checks++; if ({bus.TRANSFER, bus.RSP_VALID, bus.PWRITE_MASTER} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b exp 000", {bus.TRANSFER, bus.RSP_VALID, bus.PWRITE_MASTER}); end
    checks++; if (bus.LEVEL !== LW'(0)) begin
      errors++; $display("FAIL reset_level: got %0d exp 0", bus.LEVEL); end
    checks++; if (bus.PADDR_MASTER !== 32'h0 || bus.PWDATA_MASTER !== 32'h0) begin
      errors++; $display("FAIL reset_master: got %h/%h exp 0/0", bus.PADDR_MASTER, bus.PWDATA_MASTER); end
    checks++; if (bus.RSP_DATA !== 32'h0 || bus.RSP_ADDR !== 32'h0) begin
      errors++; $display("FAIL reset_rsp: got %h/%h exp 0/0", bus.RSP_DATA, bus.RSP_ADDR); end
    rst = 0; bus.CMD_VALID = 0;
    tick();
    checks++; if (bus.CMD_READY !== 1'b1 || bus.LEVEL !== LW'(0)) begin
      errors++; $display("FAIL reset_after: ready %b level %0d exp 1/0", bus.CMD_READY, bus.LEVEL); end
  endtask

  task automatic test_single_write();
    bit ok;
    push_cmd(1, 32'h0, 32'h4);
    checks++; if (bus.LEVEL !== LW'(1)) begin
      errors++; $display("FAIL single_level: got %0d exp 1", bus.LEVEL); end
    wait_transfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_transfer: got 0 exp 1 within 20 cycles"); end
    checks++; if ({bus.PWRITE_MASTER, bus.PADDR_MASTER, bus.PWDATA_MASTER} !== {1'b1, 32'h0, 32'h4}) begin
      errors++; $display("FAIL single_cmd: got %b/%h/%h exp 1/0/4", bus.PWRITE_MASTER, bus.PADDR_MASTER, bus.PWDATA_MASTER); end
    apb_run(0, 32'h0);
    checks++; if (bus.LEVEL !== LW'(0) || bus.TRANSFER !== 1'b0 || bus.RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL single_done: level %0d transfer %b rsp %b exp 0/0/0", bus.LEVEL, bus.TRANSFER, bus.RSP_VALID); end
    tick();
    checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL single_norsp: got 1 exp 0"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    d[0] = 32'h4; d[1] = 32'h2112023; d[2] = 32'h178190; d[3] = 32'h186129;
    bus.CMD_VALID = 1; bus.CMD_WRITE = 1;
    for (int i = 0; i < 4; i++) begin
      bus.CMD_ADDR = 32'(i * 4); bus.CMD_WDATA = d[i];
      tick();
    end
    bus.CMD_VALID = 0;
    checks++; if (bus.LEVEL !== LW'(4) || bus.CMD_READY !== 1'b0) begin
      errors++; $display("FAIL b2b_fill: level %0d ready %b exp 4/0", bus.LEVEL, bus.CMD_READY); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.TRANSFER !== 1'b1 || bus.PADDR_MASTER !== 32'(i * 4) || bus.PWDATA_MASTER !== d[i]) begin
        errors++; $display("FAIL b2b_issue%0d: transfer %b addr %h data %h exp 1/%h/%h",
                           i, bus.TRANSFER, bus.PADDR_MASTER, bus.PWDATA_MASTER, i * 4, d[i]); end
      apb_run(i % 2, 32'h0);
    end
    checks++; if (bus.LEVEL !== LW'(0) || bus.TRANSFER !== 1'b0) begin
      errors++; $display("FAIL b2b_end: level %0d transfer %b exp 0/0", bus.LEVEL, bus.TRANSFER); end
  endtask

  task automatic test_read();
    bit ok;
    push_cmd(0, 32'h4, 32'h0);
    wait_transfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_transfer: got 0 exp 1 within 20 cycles"); end
    apb_run(1, 32'h2112023);
    checks++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 32'h2112023 || bus.RSP_ADDR !== 32'h4) begin
      errors++; $display("FAIL read_rsp: valid %b data %h addr %h exp 1/2112023/4", bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ADDR); end
    tick();
    checks++; if (bus.RSP_VALID !== 1'b0 || bus.RSP_DATA !== 32'h2112023 || bus.RSP_ADDR !== 32'h4) begin
      errors++; $display("FAIL read_hold: valid %b data %h addr %h exp 0/2112023/4", bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ADDR); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_cmd(1, 32'h10 + 32'(i * 4), 32'h100 + 32'(i));
    checks++; if (bus.LEVEL !== LW'(4) || bus.CMD_READY !== 1'b0) begin
      errors++; $display("FAIL full_fill: level %0d ready %b exp 4/0", bus.LEVEL, bus.CMD_READY); end
    push_cmd(1, 32'h40, 32'hBAD);
    checks++; if (bus.LEVEL !== LW'(4)) begin errors++; $display("FAIL full_drop: level %0d exp 4", bus.LEVEL); end
    bus.PSEL = 1; bus.PENABLE = 0;
    tick();
    bus.PENABLE = 1; bus.PREADY = 1;
    bus.CMD_VALID = 1; bus.CMD_WRITE = 1; bus.CMD_ADDR = 32'h50; bus.CMD_WDATA = 32'hBAD;
    tick();
    idle_inputs();
    checks++; if (bus.LEVEL !== LW'(3) || bus.CMD_READY !== 1'b1) begin
      errors++; $display("FAIL full_pushpop: level %0d ready %b exp 3/1", bus.LEVEL, bus.CMD_READY); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (bus.TRANSFER !== 1'b1 || bus.PADDR_MASTER !== 32'h10 + 32'(i * 4) || bus.PWDATA_MASTER !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL full_drain%0d: transfer %b addr %h data %h exp 1/%h/%h",
                           i, bus.TRANSFER, bus.PADDR_MASTER, bus.PWDATA_MASTER, 32'h10 + i * 4, 32'h100 + i); end
      apb_run(0, 32'h0);
    end
    checks++; if (bus.LEVEL !== LW'(0) || bus.TRANSFER !== 1'b0) begin
      errors++; $display("FAIL full_end: level %0d transfer %b exp 0/0", bus.LEVEL, bus.TRANSFER); end
  endtask

  task automatic test_wait_states();
    bit ok;
    push_cmd(1, 32'h20, 32'hAB);
    wait_transfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wait_transfer: got 0 exp 1 within 20 cycles"); end
    bus.PSEL = 1; bus.PENABLE = 0;
    tick();
    bus.PENABLE = 1; bus.PREADY = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.TRANSFER !== 1'b1 || bus.LEVEL !== LW'(1) || bus.PADDR_MASTER !== 32'h20 || bus.PWDATA_MASTER !== 32'hAB) begin
        errors++; $display("FAIL wait_hold%0d: transfer %b level %0d addr %h data %h exp 1/1/20/ab",
                           i, bus.TRANSFER, bus.LEVEL, bus.PADDR_MASTER, bus.PWDATA_MASTER); end
    end
    bus.PREADY = 1;
    tick();
    idle_inputs();
    checks++; if (bus.LEVEL !== LW'(0) || bus.TRANSFER !== 1'b0) begin
      errors++; $display("FAIL wait_done: level %0d transfer %b exp 0/0", bus.LEVEL, bus.TRANSFER); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    push_cmd(0, 32'h30, 32'h0);
    push_cmd(0, 32'h34, 32'h0);
    push_cmd(0, 32'h38, 32'h0);
    wait_transfer(ok);
    checks++; if (!ok || bus.LEVEL !== LW'(3)) begin
      errors++; $display("FAIL rstmid_setup: transfer %b level %0d exp 1/3", bus.TRANSFER, bus.LEVEL); end
    bus.PSEL = 1; bus.PENABLE = 0;
    tick();
    bus.PENABLE = 1; bus.PREADY = 0;
    tick();
    rst = 1; bus.PREADY = 1; bus.PRDATA_MASTER = 32'hDEAD;
    tick();
    rst = 0; idle_inputs();
    checks++; if (bus.LEVEL !== LW'(0) || bus.TRANSFER !== 1'b0 || bus.RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: level %0d transfer %b rsp %b exp 0/0/0", bus.LEVEL, bus.TRANSFER, bus.RSP_VALID); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.RSP_VALID !== 1'b0 || bus.TRANSFER !== 1'b0 || bus.LEVEL !== LW'(0)) begin
        errors++; $display("FAIL rstmid_quiet%0d: rsp %b transfer %b level %0d exp 0/0/0", i, bus.RSP_VALID, bus.TRANSFER, bus.LEVEL); end
    end
  endtask

  // Model: a queue of accepted commands in arrival order; the head is what the
  // bus must see, and a completed read must echo its data and address.
  task automatic test_random();
    cmd_t        q[$];
    cmd_t        c;
    bit          exp_v = 0;
    logic [31:0] exp_d = 32'h0, exp_a = 32'h0, prd;
    int          phase = 0, stall = 0;
    bit          acc, cmp;
    for (int n = 0; n < 400; n++) begin
      checks++; if (bus.LEVEL !== LW'(q.size()) || bus.CMD_READY !== 1'(q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_level@%0d: level %0d ready %b exp %0d/%0d", n, bus.LEVEL, bus.CMD_READY, q.size(), q.size() < DEPTH); end
      checks++; if (bus.RSP_VALID !== exp_v || bus.RSP_DATA !== exp_d || bus.RSP_ADDR !== exp_a) begin
        errors++; $display("FAIL rnd_rsp@%0d: %b/%h/%h exp %b/%h/%h", n, bus.RSP_VALID, bus.RSP_DATA, bus.RSP_ADDR, exp_v, exp_d, exp_a); end
      if (bus.TRANSFER === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_head@%0d: transfer 1 exp 0 with empty queue", n);
        end else if ({bus.PWRITE_MASTER, bus.PADDR_MASTER, bus.PWDATA_MASTER} !== q[0]) begin
          errors++; $display("FAIL rnd_head@%0d: got %b/%h/%h exp %b/%h/%h", n, bus.PWRITE_MASTER, bus.PADDR_MASTER,
                             bus.PWDATA_MASTER, q[0].write, q[0].addr, q[0].wdata);
        end
      end
      stall = (bus.TRANSFER !== 1'b1 && q.size() > 0) ? stall + 1 : 0;
      checks++; if (stall > 1 || (phase == 2 && bus.TRANSFER !== 1'b1)) begin
        errors++; $display("FAIL rnd_progress@%0d: transfer %b stall %0d exp transfer 1", n, bus.TRANSFER, stall); end

      bus.CMD_VALID = ($urandom_range(0, 9) < 4);
      bus.CMD_WRITE = 1'($urandom_range(0, 1));
      bus.CMD_ADDR  = 32'($urandom_range(0, 255)) << 2;
      bus.CMD_WDATA = $urandom;
      prd = $urandom;
      bus.PRDATA_MASTER = prd;
      bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0;
      cmp = 0;
      if (phase == 2) begin
        bus.PSEL = 1; bus.PENABLE = 1; bus.PREADY = ($urandom_range(0, 2) != 0);
        cmp = bus.PREADY;
        if (cmp) phase = 0;
      end else if (bus.TRANSFER === 1'b1) begin
        bus.PSEL = 1;
        phase = 2;
      end
      acc = bus.CMD_VALID && (q.size() < DEPTH);
      exp_v = 0;
      if (cmp && q.size() > 0) begin
        c = q.pop_front();
        if (!c.write) begin exp_v = 1; exp_d = prd; exp_a = c.addr; end
      end
      if (acc) q.push_back(cmd_t'({bus.CMD_WRITE, bus.CMD_ADDR, bus.CMD_WDATA}));
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read();
    test_full();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 exp finished");
    $fatal(1, "watchdog");
  end
endmodule
